// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I fetch types and constants
// Purpose: widths, the canonical NOP, the fetch-state enum and the fetch
// buffer entry struct. HALT is only reached when HALT_ON_ZERO_EN is defined.
// Ports: none (package).
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FAULT = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instruction fetch addresses are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-to-decode valid/ready handshake bundle
// Purpose: carries the head of the fetch buffer to decode.
// Signals: if_valid (head holds an instruction), if_ready (decode accepts),
//          if_pc / if_inst (PC and word of the head entry).
// Modports: master = fetch side, slave = decode side.
interface instr_fetch_if;
  import rv32i_pkg::*;

  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;

  modport master (output if_valid, output if_pc, output if_inst, input if_ready);
  modport slave  (input if_valid, input if_pc, input if_inst, output if_ready);

endinterface

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - 2-entry fetch FIFO with flush and same-cycle push/pop
// Purpose: holds fetched {pc, inst} entries until decode takes them.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        drop all entries and reset pointers (wins over push)
//   push         write push_entry at the write pointer
//   push_entry   entry to write
//   pop          retire the head entry
//   head_entry   entry at the read pointer (zero after reset)
//   count        number of valid entries (0..2)
module fetch_buf
  import rv32i_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head_entry,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count_q;

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      // When full with a pop, wr_ptr == rd_ptr: the slot being overwritten
      // is the one decode is consuming this cycle.
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_entry = mem[rd_ptr];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC generation and fetch buffer ahead of decode
// Purpose: drives the combinational ROM address, buffers {pc, inst} in a
// 2-entry FIFO and hands them to decode; handles redirects and stops on an
// out-of-range fetch. Optional macro HALT_ON_ZERO_EN: an all-zero word stops
// fetching in HALT and raises halted until the next redirect.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   imem_addr        ROM byte address (the pc register)
//   imem_inst        ROM word at imem_addr, same cycle
//   redirect_valid   one-cycle taken branch/jump pulse
//   redirect_pc      redirect target, low two bits ignored
//   dec              decode handshake (if_valid/if_ready/if_pc/if_inst)
//   fetch_fault      sticky out-of-range fetch flag
//   halted           (HALT_ON_ZERO_EN only) state is HALT
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              MEM_BYTES = 1024,
  parameter int              DEPTH     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INST_W-1:0]  imem_inst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  instr_fetch_if.master      dec,
`ifdef HALT_ON_ZERO_EN
  output logic               halted,
`endif
  output logic               fetch_fault
);

  localparam logic [XLEN-1:0] LAST_ADDR  = XLEN'(MEM_BYTES - 4);
  localparam logic [1:0]      FULL_COUNT = 2'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;

  logic            in_range;
  logic            pop;
  logic            room;
  logic            push;
  logic            flush;
  logic [1:0]      count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  assign in_range = (pc_q <= LAST_ADDR);
  assign pop      = dec.if_valid & dec.if_ready;
  // A full buffer still has room when decode drains the head this cycle.
  assign room     = (count < FULL_COUNT) | pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    flush   = 1'b0;

    if (redirect_valid) begin
      // Any pop this cycle still completes; the flush only drops the rest.
      state_d = FETCH;
      pc_d    = word_align(redirect_pc);
      flush   = 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          if (!in_range) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else if (room) begin
`ifdef HALT_ON_ZERO_EN
            if (imem_inst == '0) begin
              state_d = HALT;
            end else begin
              push = 1'b1;
              pc_d = pc_q + 32'd4;
            end
`else
            push = 1'b1;
            pc_d = pc_q + 32'd4;
`endif
          end
        end
        default: begin
          // FAULT and HALT wait for a redirect.
        end
      endcase
    end
  end

  assign push_entry = '{pc: pc_q, inst: imem_inst};

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count)
  );

  assign imem_addr   = pc_q;
  assign fetch_fault = fault_q;
  assign dec.if_valid = (count != 2'd0);
  assign dec.if_pc    = head_entry.pc;
  assign dec.if_inst  = head_entry.inst;

`ifdef HALT_ON_ZERO_EN
  assign halted = (state_q == HALT);
`endif

endmodule
